// File: rtl/pll_cfg_pkg.sv
// ----------------------------------------------------------------------------
// pll_cfg_pkg
// Shared types and constants for the PLL serial-configuration master.
//   state_t          : controller state encoding
//   CFG_WORD_BITS    : length of the PLL scan chain
//   *_LSB / *_W      : bit offset and width of each field in the word
// ----------------------------------------------------------------------------
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        SETTLE,
        DONE
    } state_t;

    localparam int CFG_WORD_BITS = 26;

    // Field layout, LSB first; DIVR lands in the MSBs and is shifted out first.
    localparam int SHIFTREG_DIV_MODE_LSB = 0;
    localparam int SHIFTREG_DIV_MODE_W   = 1;
    localparam int FDA_RELATIVE_LSB      = 1;
    localparam int FDA_RELATIVE_W        = 4;
    localparam int FDA_FEEDBACK_LSB      = 5;
    localparam int FDA_FEEDBACK_W        = 4;
    localparam int FILTER_RANGE_LSB      = 9;
    localparam int FILTER_RANGE_W        = 3;
    localparam int DIVQ_LSB              = 12;
    localparam int DIVQ_W                = 3;
    localparam int DIVF_LSB              = 15;
    localparam int DIVF_W                = 7;
    localparam int DIVR_LSB              = 22;
    localparam int DIVR_W                = 4;

endpackage

// File: rtl/pll_cfg_shifter_if.sv
// ----------------------------------------------------------------------------
// pll_cfg_shifter_if
// Request/response bundle between a control block and the configuration
// shifter.
//   start   : request a load (master -> slave)
//   cfg_in  : configuration word (master -> slave)
//   busy    : load in progress (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   cfg_out : readback word (slave -> master)
// ----------------------------------------------------------------------------
interface pll_cfg_shifter_if #(
    parameter int CFG_BITS = 26
);
    logic                start;
    logic [CFG_BITS-1:0] cfg_in;
    logic                busy;
    logic                done;
    logic [CFG_BITS-1:0] cfg_out;

    modport master (output start, cfg_in, input busy, done, cfg_out);
    modport slave  (input start, cfg_in, output busy, done, cfg_out);
endinterface

// File: rtl/pll_cfg_tick.sv
// ----------------------------------------------------------------------------
// pll_cfg_tick
// Phase timer: counts CLK_DIV cycles from each load.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   load : restart the phase (asserted on the edge that enters a state)
//   tc   : high in the last cycle of the phase
// ----------------------------------------------------------------------------
module pll_cfg_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);
    localparam int                CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]     RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Loading CLK_DIV-1 makes a phase last exactly CLK_DIV cycles,
    // including CLK_DIV=1 where the first cycle is already terminal.
    assign tc = (cnt == '0);
endmodule

// File: rtl/pll_cfg_shifter.sv
// ----------------------------------------------------------------------------
// pll_cfg_shifter
// Serial-configuration master for the PLL test port. Shifts a CFG_BITS word
// MSB first on sdi/sclk while holding the PLL in reset, then releases it.
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : start/cfg_in/busy/done/cfg_out (slave modport)
//   sclk, sdi  : scan clock and data to the PLL (flop outputs)
//   sdo        : scan data from the PLL
//   pll_resetb : active-low PLL reset (flop output)
// Build option: define PLL_CFG_READBACK_EN to capture sdo into cfg_out;
// otherwise cfg_out is tied to zero and sdo is ignored.
// ----------------------------------------------------------------------------
module pll_cfg_shifter
    import pll_cfg_pkg::*;
#(
    parameter int CFG_BITS = 26,
    parameter int CLK_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_cfg_shifter_if.slave      bus,
    output logic                  sclk,
    output logic                  sdi,
    input  logic                  sdo,
    output logic                  pll_resetb
);
    localparam int BW = $clog2(CFG_BITS + 1);

    state_t              state, next_state;
    logic [CFG_BITS-1:0] data_q;
    logic [BW-1:0]       bit_cnt;
    logic                tc;
    logic                phase_load;
    logic                hi_exit;
    logic                accept;
    logic                busy_q;
    logic                done_q;

    assign accept     = (state == IDLE) && bus.start;
    assign hi_exit    = (state == SHIFT_HI) && tc;
    assign phase_load = (next_state != state);

    pll_cfg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (phase_load),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.start) next_state = SHIFT_LO;
            SHIFT_LO: if (tc)        next_state = SHIFT_HI;
            SHIFT_HI: if (tc)        next_state = (bit_cnt == BW'(1)) ? SETTLE : SHIFT_LO;
            SETTLE:   if (tc)        next_state = DONE;
            DONE:                    next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Pin-level outputs are registered from next_state so they change on the
    // same edge as the state and never glitch.
    // NOTE: the shift register is reset even though it is reloaded on accept,
    // because sdi is taken straight from its MSB and must be 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            pll_resetb <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                data_q  <= bus.cfg_in;
                bit_cnt <= BW'(CFG_BITS);
            end else if (hi_exit) begin
                // Zeros fill from the LSB, so sdi is 0 once the word is out.
                data_q  <= data_q << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
            sclk   <= (next_state == SHIFT_HI);
            busy_q <= (next_state == SHIFT_LO) || (next_state == SHIFT_HI) ||
                      (next_state == SETTLE);
            done_q <= (next_state == DONE);
            // Released in DONE; held low during any load; kept as-is in IDLE.
            if (next_state == DONE)
                pll_resetb <= 1'b1;
            else if (next_state != IDLE)
                pll_resetb <= 1'b0;
        end
    end

    assign sdi      = data_q[CFG_BITS-1];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef PLL_CFG_READBACK_EN
    logic [CFG_BITS-1:0] rb_q;
    logic [CFG_BITS-1:0] cfg_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q      <= '0;
            cfg_out_q <= '0;
        end else begin
            if (hi_exit)
                rb_q <= (rb_q << 1) | CFG_BITS'(sdo);
            // Last capture happened at the final SHIFT_HI exit, so rb_q is
            // complete by the time SETTLE hands over to DONE.
            if (next_state == DONE)
                cfg_out_q <= rb_q;
        end
    end

    assign bus.cfg_out = cfg_out_q;
`else
    logic unused_sdo;
    assign unused_sdo  = sdo;
    assign bus.cfg_out = '0;
`endif

endmodule

// File: tb/tb_pll_cfg_shifter.sv
// ----------------------------------------------------------------------------
// tb_pll_cfg_shifter
// Directed bench for pll_cfg_shifter: a 26-bit / CLK_DIV=2 instance with an
// sdo loopback model, and a 1-bit / CLK_DIV=1 instance for the minimum case.
// Expected readback depends on PLL_CFG_READBACK_EN.
// ----------------------------------------------------------------------------
module tb_pll_cfg_shifter;
    import pll_cfg_pkg::*;

`ifdef PLL_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sclk, sdi, sdo, pll_resetb;
    logic s_sclk, s_sdi, s_sdo, s_resetb;

    // PLL scan-chain model: sdo is its MSB; captures sdi on sclk rise and
    // shifts on sclk fall (updated by the run task, never by the DUT).
    logic [25:0] m;
    logic [25:0] word;
    logic        cap;
    assign sdo = m[25];

    int vectors     = 0;
    int miscompares = 0;

    int          rises, hi_cycles, sdi_bad, resetb_bad, cfg_chg_bad;
    int          done_at[$];
    logic [25:0] rb_at_done[$];
    logic        busy_log [0:299];

    pll_cfg_shifter_if #(.CFG_BITS(26)) m_if ();
    pll_cfg_shifter_if #(.CFG_BITS(1))  s_if ();

    pll_cfg_shifter #(.CFG_BITS(26), .CLK_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (m_if.slave),
        .sclk       (sclk),
        .sdi        (sdi),
        .sdo        (sdo),
        .pll_resetb (pll_resetb)
    );

    pll_cfg_shifter #(.CFG_BITS(1), .CLK_DIV(1)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .bus        (s_if.slave),
        .sclk       (s_sclk),
        .sdi        (s_sdi),
        .sdo        (s_sdo),
        .pll_resetb (s_resetb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps cycles k_first..k_last after an accept, tracking the main DUT.
    // start is dropped after sampling cycle 'hold'.
    task automatic run(input int k_first, input int k_last, input int hold);
        logic        prev_sclk;
        logic [25:0] prev_cfg;
        rises = 0; hi_cycles = 0; sdi_bad = 0; resetb_bad = 0; cfg_chg_bad = 0;
        done_at.delete();
        rb_at_done.delete();
        prev_sclk = sclk;
        prev_cfg  = m_if.cfg_out;
        for (int k = k_first; k <= k_last; k++) begin
            step();
            if (k < 300) busy_log[k] = m_if.busy;
            if (sclk && !prev_sclk) begin
                if (sdi !== word[25 - (rises % 26)]) sdi_bad++;
                cap = sdi;
                rises++;
            end
            if (!sclk && prev_sclk) m = {m[24:0], cap};
            if (sclk) hi_cycles++;
            if (m_if.done) begin
                done_at.push_back(k);
                rb_at_done.push_back(m_if.cfg_out);
                if (pll_resetb !== 1'b1 || m_if.busy !== 1'b0) resetb_bad++;
            end else if (m_if.busy && pll_resetb !== 1'b0) begin
                resetb_bad++;
            end
            if (m_if.cfg_out !== prev_cfg && !m_if.done) cfg_chg_bad++;
            prev_sclk = sclk;
            prev_cfg  = m_if.cfg_out;
            if (k >= hold) m_if.start = 1'b0;
        end
    endtask

    initial begin
        int s_hi, s_done_at;
        logic s_rb, s_rstb;

        rst = 1'b1;
        m_if.start = 1'b0; m_if.cfg_in = '0;
        s_if.start = 1'b0; s_if.cfg_in = '0;
        s_sdo = 1'b0; m = '0; word = '0; cap = 1'b0;
        repeat (3) step();

        check("rst_busy",   m_if.busy,    0);
        check("rst_done",   m_if.done,    0);
        check("rst_sclk",   sclk,         0);
        check("rst_sdi",    sdi,          0);
        check("rst_resetb", pll_resetb,   0);
        check("rst_cfgout", m_if.cfg_out, 0);
        check("rst_s_busy", s_if.busy,    0);

        rst = 1'b0;
        repeat (5) step();
        check("idle_busy",   m_if.busy,  0);
        check("idle_resetb", pll_resetb, 0);

        // Load 1: single start pulse, readback of preloaded chain.
        word = 26'h2A55A5A;
        m    = 26'h1234567;
        m_if.cfg_in = word;
        m_if.start  = 1'b1;
        step();
        check("t1_c1_busy",   m_if.busy,  1);
        check("t1_c1_sdi",    sdi,        1);
        check("t1_c1_sclk",   sclk,       0);
        check("t1_c1_resetb", pll_resetb, 0);
        m_if.start = 1'b0;
        run(2, 150, 1);
        check("t1_done_count", done_at.size(), 1);
        check("t1_done_cycle", done_at.size() > 0 ? done_at[0] : -1, 107);
        check("t1_sclk_rises", rises,       26);
        check("t1_sclk_high",  hi_cycles,   52);
        check("t1_sdi_order",  sdi_bad,     0);
        check("t1_resetb",     resetb_bad,  0);
        check("t1_cfg_stable", cfg_chg_bad, 0);
        check("t1_readback", rb_at_done.size() > 0 ? rb_at_done[0] : 26'h3FFFFFF,
              RB ? 26'h1234567 : 26'h0);
        check("t1_end_resetb", pll_resetb, 1);
        check("t1_end_busy",   m_if.busy,  0);

        // start held for 200 cycles: two loads, none starting in DONE.
        m = 26'h0ABCDEF;
        m_if.start = 1'b1;
        run(1, 260, 200);
        check("t2_done_count", done_at.size(), 2);
        check("t2_done0", done_at.size() > 0 ? done_at[0] : -1, 107);
        check("t2_done1", done_at.size() > 1 ? done_at[1] : -1, 215);
        check("t2_busy_108", busy_log[108], 0);
        check("t2_busy_109", busy_log[109], 1);
        check("t2_sclk_rises", rises,   52);
        check("t2_sdi_order",  sdi_bad, 0);
        check("t2_rb0", rb_at_done.size() > 0 ? rb_at_done[0] : 26'h3FFFFFF,
              RB ? 26'h0ABCDEF : 26'h0);
        check("t2_rb1", rb_at_done.size() > 1 ? rb_at_done[1] : 26'h3FFFFFF,
              RB ? 26'h2A55A5A : 26'h0);
        check("t2_cfg_stable", cfg_chg_bad, 0);

        // Reset in the middle of a load.
        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        run(2, 40, 1);
        rst = 1'b1;
        step();
        check("t3_busy",    m_if.busy,    0);
        check("t3_done",    m_if.done,    0);
        check("t3_sclk",    sclk,         0);
        check("t3_sdi",     sdi,          0);
        check("t3_resetb",  pll_resetb,   0);
        check("t3_cfgout",  m_if.cfg_out, 0);
        rst = 1'b0;
        run(1, 150, 1);
        check("t3_no_done", done_at.size(), 0);

        // Fresh load after the abandoned one.
        word = 26'h0F0F0F3;
        m    = 26'h2C0FFEE;
        m_if.cfg_in = word;
        m_if.start  = 1'b1;
        step();
        m_if.start = 1'b0;
        run(2, 150, 1);
        check("t4_done_cycle", done_at.size() > 0 ? done_at[0] : -1, 107);
        check("t4_sclk_rises", rises,   26);
        check("t4_sdi_order",  sdi_bad, 0);
        check("t4_readback", rb_at_done.size() > 0 ? rb_at_done[0] : 26'h3FFFFFF,
              RB ? 26'h2C0FFEE : 26'h0);

        // Minimum case: CLK_DIV=1, CFG_BITS=1.
        s_hi = 0; s_done_at = -1; s_rb = 1'b0; s_rstb = 1'b0;
        s_sdo = 1'b1;
        s_if.cfg_in = 1'b1;
        s_if.start  = 1'b1;
        step();
        check("t5_c1_busy", s_if.busy, 1);
        check("t5_c1_sdi",  s_sdi,     1);
        s_if.start = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (s_sclk) s_hi++;
            if (s_if.done && s_done_at < 0) begin
                s_done_at = k;
                s_rb      = s_if.cfg_out[0];
                s_rstb    = s_resetb;
            end
        end
        check("t5_sclk_high",  s_hi,      1);
        check("t5_done_cycle", s_done_at, 4);
        check("t5_resetb",     s_rstb,    1);
        check("t5_readback",   s_rb,      RB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
